rd_bus_arbiter: RTL and testbench
=================================

# rd_bus_arbiter

Two-master, one-slave AXI-lite read-channel arbiter. It shares a single read port (the unified Ram read slave) between the core's instruction-fetch master (M0) and data-load master (M1). It grants the port round-robin and holds the grant for a whole transaction. A response watchdog returns SLVERR to the master if the slave does not answer, so the core never stalls forever. The block sits between the core bus matrices and the memory slave, on the ACLK domain.

## Interface
- ADDR_W, 64, address width of all AR channels
- DATA_W, 64, data width of all R channels
- TIMEOUT, 255, number of DATA-state cycles without S_RVALID before the watchdog fires (1..2^CNT_W-1)
- CNT_W, 8, watchdog counter width
- ACLK  in  1  single clock; all logic on rising edge
- ARESETn  in  1  asynchronous active-low reset
- M0_ARVALID / M1_ARVALID  in  1  master read-address valid
- M0_ARADDR / M1_ARADDR  in  ADDR_W  master read address
- M0_ARREADY / M1_ARREADY  out  1  address accepted
- M0_RVALID / M1_RVALID  out  1  read data valid to master
- M0_RDATA / M1_RDATA  out  DATA_W  read data
- M0_RRESP / M1_RRESP  out  2  response; 2'b00 OKAY, 2'b10 SLVERR
- M0_RREADY / M1_RREADY  in  1  master ready for data
- S_ARVALID  out  1  slave address valid
- S_ARADDR  out  ADDR_W  slave address (registered)
- S_ARREADY  in  1  slave address ready
- S_RVALID  in  1  slave data valid
- S_RDATA  in  DATA_W  slave data
- S_RRESP  in  2  slave response
- S_RREADY  out  1  ready to slave
- Grant  out  2  one-hot current owner (bit0 = M0, bit1 = M1); 2'b00 when idle
- TimeoutErr  out  1  one-cycle pulse when the watchdog fires

## Operation
- FSM states: IDLE, ADDR, DATA, ERR, DRAIN.
- **IDLE**
  - With no request, all outputs are 0.
  - With one request, that master wins.
  - With both requesting, the master not in LastGnt wins.
  - The winner sees Mx_ARREADY=1 combinationally in the same cycle. Its ARADDR is latched into S_ARADDR and the owner is registered. LastGnt updates to the winner. Next state is ADDR.
- **ADDR**
  - S_ARVALID=1 and S_ARADDR is held stable.
  - On S_ARVALID & S_ARREADY, go to DATA and clear the watchdog counter.
  - There is no timeout in ADDR.
- **DATA**
  - Combinational pass-through to the owner: Mg_RVALID=S_RVALID, Mg_RDATA=S_RDATA, Mg_RRESP=S_RRESP, S_RREADY=Mg_RREADY.
  - Non-owner R outputs are 0.
  - On the S_RVALID & Mg_RREADY handshake, go to IDLE.
  - Each cycle with S_RVALID=0, the counter increments, saturating.
  - When the counter equals TIMEOUT and S_RVALID=0, pulse TimeoutErr and go to ERR.
- **ERR**
  - Drives Mg_RVALID=1, Mg_RDATA=0, Mg_RRESP=2'b10 and S_RREADY=0.
  - On Mg_RREADY, go to DRAIN.
- **DRAIN**
  - Master outputs are 0 and S_RREADY=1. The late slave beat is discarded.
  - On S_RVALID, go to IDLE.
  - DRAIN is unbounded by design; a dead slave keeps the port blocked, but the master has already been released.
- Grant reflects the registered owner in ADDR, DATA, ERR and DRAIN, and is 00 in IDLE.

## Timing
- Reset (asynchronous, any state):
  - State goes to IDLE; S_ARADDR=0, owner=none, counter=0.
  - LastGnt=M0, so M1 wins the first tie.
  - Every output deasserts immediately: all ARREADY, RVALID, RDATA, RRESP, S_ARVALID, S_RREADY, Grant and TimeoutErr go to 0.
  - An in-flight slave transaction is abandoned; the slave must also be reset.
- Minimum latency, from Mx_ARVALID sampled in IDLE to Mx_RVALID, with the slave ready and responding the cycle after the AR handshake:
  - cycle 0: accept;
  - cycle 1: S_ARVALID and AR handshake;
  - cycle 2: S_RVALID passes through to Mx_RVALID.
- Back-to-back: after the R handshake the FSM returns to IDLE, so a new accept takes one IDLE cycle and throughput is at most 1 transfer per 3 cycles.
- A master asserting ARVALID while the other owns the port sees ARREADY=0 until the next IDLE cycle. It must hold ARVALID and ARADDR (AXI rule).
- Simultaneous S_RVALID and counter==TIMEOUT: data wins, the transfer is normal and there is no error.
- Watchdog fires TIMEOUT+1 cycles after entering DATA with S_RVALID continuously 0. TimeoutErr is high for exactly one cycle, on the DATA->ERR transition cycle.
- LastGnt updates only on an IDLE accept.

## Test plan
- Reset then M1_ARVALID with addr 0x8000_0010; slave returns 0xDEAD_BEEF one cycle after the AR handshake -> M1_ARREADY at cycle 0, S_ARADDR=0x8000_0010 at cycle 1, M1_RVALID with RDATA=0xDEAD_BEEF, RRESP=00 at cycle 2, Grant=2'b10 during cycles 1-2.
- M0 and M1 request together continuously for 4 transactions -> grant order M1, M0, M1, M0; each master sees exactly 2 R beats.
- M0 owns the port with the slave holding S_ARREADY=0 for 5 cycles; M1 requests meanwhile -> M1_ARREADY stays 0 until M0's R handshake completes and IDLE is reached, and S_ARADDR stays stable for all 5 cycles.
- TIMEOUT=4, slave never asserts RVALID -> TimeoutErr pulses 5 cycles after entering DATA. The owner then gets RVALID=1, RDATA=0, RRESP=2'b10. A slave beat arriving 3 cycles later is swallowed with S_RREADY=1, and the FSM returns to IDLE.
- ARESETn pulled low mid-DATA -> in the same cycle all outputs are 0 and Grant=00. After release, a tie grants M1 first.
- Master holds RREADY=0 for 3 cycles while S_RVALID=1 -> S_RREADY=0 for those cycles, data is held, no timeout is raised, and exactly one handshake occurs.

Source files
------------

// File: rtl/rd_bus_arbiter_if.sv
// AXI-lite read-channel bundle (AR + R) shared by both masters and the slave port.
interface rd_bus_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              ARVALID;
  logic              ARREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic              RVALID;
  logic              RREADY;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;

  // Side that issues reads
  modport master (
    output ARVALID, ARADDR, RREADY,
    input  ARREADY, RVALID, RDATA, RRESP
  );

  // Side that serves reads
  modport slave (
    input  ARVALID, ARADDR, RREADY,
    output ARREADY, RVALID, RDATA, RRESP
  );
endinterface

// File: rtl/rd_bus_arbiter.sv
// rd_bus_arbiter: shares one AXI-lite read slave between the instruction-fetch
// master (m0) and the data-load master (m1). Round-robin grant held for a whole
// transaction; a response watchdog answers SLVERR if the slave goes silent.
//
// state | meaning
// IDLE  | no owner; arbitrate and accept one AR combinationally
// ADDR  | present the latched address to the slave until it is accepted
// DATA  | pass the R channel through to the owner; watchdog running
// ERR   | watchdog fired; return SLVERR to the owner
// DRAIN | owner released; swallow the late slave beat
module rd_bus_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  rd_bus_arbiter_if.slave       m0,
  rd_bus_arbiter_if.slave       m1,
  rd_bus_arbiter_if.master      s,
  output logic [1:0]            Grant,
  output logic                  TimeoutErr
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_ERR,
    ST_DRAIN
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        owner_q, owner_d;  // one-hot, bit0 = m0
  logic              last_q, last_d;    // last winner: 0 = m0, 1 = m1
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic win1;
  logic accept;
  logic own_rready;
  logic fire;

  // Arbitration, owner's RREADY select and watchdog terminal condition
  always_comb begin
    win1       = m1.ARVALID & (~m0.ARVALID | ~last_q);
    accept     = ARESETn & (state_q == ST_IDLE) & (m0.ARVALID | m1.ARVALID);
    own_rready = owner_q[1] ? m1.RREADY : m0.RREADY;
    fire       = (state_q == ST_DATA) & ~s.RVALID & (cnt_q == TIMEOUT_C);
  end

  // Next-state and datapath register update
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_ADDR;
          owner_d = win1 ? 2'b10 : 2'b01;
          last_d  = win1;
          addr_d  = win1 ? m1.ARADDR : m0.ARADDR;
        end
      end
      ST_ADDR: begin
        if (s.ARREADY) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end
      end
      ST_DATA: begin
        // A beat arriving on the terminal count still wins over the watchdog.
        if (s.RVALID && own_rready) begin
          state_d = ST_IDLE;
        end else if (fire) begin
          state_d = ST_ERR;
        end else if (!s.RVALID && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ERR: begin
        if (own_rready) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (s.RVALID) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if ((state_d == ST_IDLE) && (state_q != ST_IDLE)) begin
      owner_d = 2'b00;
      addr_d  = '0;
    end
  end

  // Output decode; everything is forced low while reset is asserted
  always_comb begin
    m0.ARREADY = 1'b0;
    m0.RVALID  = 1'b0;
    m0.RDATA   = '0;
    m0.RRESP   = 2'b00;
    m1.ARREADY = 1'b0;
    m1.RVALID  = 1'b0;
    m1.RDATA   = '0;
    m1.RRESP   = 2'b00;
    s.ARVALID  = 1'b0;
    s.RREADY   = 1'b0;
    Grant      = 2'b00;
    TimeoutErr = 1'b0;
    if (ARESETn) begin
      Grant = (state_q == ST_IDLE) ? 2'b00 : owner_q;
      case (state_q)
        ST_IDLE: begin
          m0.ARREADY = accept & ~win1;
          m1.ARREADY = accept & win1;
        end
        ST_ADDR: s.ARVALID = 1'b1;
        ST_DATA: begin
          m0.RVALID  = owner_q[0] & s.RVALID;
          m0.RDATA   = owner_q[0] ? s.RDATA : '0;
          m0.RRESP   = owner_q[0] ? s.RRESP : 2'b00;
          m1.RVALID  = owner_q[1] & s.RVALID;
          m1.RDATA   = owner_q[1] ? s.RDATA : '0;
          m1.RRESP   = owner_q[1] ? s.RRESP : 2'b00;
          s.RREADY   = own_rready;
          TimeoutErr = fire;
        end
        ST_ERR: begin
          m0.RVALID = owner_q[0];
          m0.RRESP  = owner_q[0] ? 2'b10 : 2'b00;
          m1.RVALID = owner_q[1];
          m1.RRESP  = owner_q[1] ? 2'b10 : 2'b00;
        end
        ST_DRAIN: s.RREADY = 1'b1;
        default: ;
      endcase
    end
  end

  assign s.ARADDR = addr_q;

  // State and datapath registers
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      owner_q <= 2'b00;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rd_bus_arbiter.sv
// Bench for rd_bus_arbiter: directed scenarios with literal expectations, then
// randomized traffic against a transaction-level reference model.
module tb_rd_bus_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int TO = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] grant;
  logic timeout_err;

  always #5 clk = ~clk;

  rd_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
  rd_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();
  rd_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) s_if ();

  rd_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .ACLK(clk), .ARESETn(rst_n), .m0(m0_if), .m1(m1_if), .s(s_if),
    .Grant(grant), .TimeoutErr(timeout_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- accessors ----------------
  function automatic logic g_arv(int i);      return i == 0 ? m0_if.ARVALID : m1_if.ARVALID; endfunction
  function automatic logic [63:0] g_ara(int i); return i == 0 ? m0_if.ARADDR : m1_if.ARADDR; endfunction
  function automatic logic g_rrdy(int i);     return i == 0 ? m0_if.RREADY : m1_if.RREADY; endfunction
  function automatic logic d_arrdy(int i);    return i == 0 ? m0_if.ARREADY : m1_if.ARREADY; endfunction
  function automatic logic d_rv(int i);       return i == 0 ? m0_if.RVALID : m1_if.RVALID; endfunction
  function automatic logic [63:0] d_rd(int i);  return i == 0 ? m0_if.RDATA : m1_if.RDATA; endfunction
  function automatic logic [1:0] d_rr(int i); return i == 0 ? m0_if.RRESP : m1_if.RRESP; endfunction

  // ---------------- reference model ----------------
  typedef enum int {FREE, AR_OUT, R_WAIT, ERR_RESP, SINK} phase_e;
  phase_e      ph = FREE;
  int          own = -1;
  int          last = 0;
  logic [63:0] maddr = '0;
  int          quiet = 0;
  int          win = -1;

  logic        e_arrdy [2];
  logic        e_rv [2];
  logic [63:0] e_rd [2];
  logic [1:0]  e_rr [2];
  logic        e_sarv, e_srrdy, e_to;
  logic [1:0]  e_gnt;

  function automatic void compute_exp();
    for (int i = 0; i < 2; i++) begin
      e_arrdy[i] = 1'b0; e_rv[i] = 1'b0; e_rd[i] = '0; e_rr[i] = 2'b00;
    end
    e_sarv = 1'b0; e_srrdy = 1'b0; e_to = 1'b0; e_gnt = 2'b00; win = -1;
    if (rst_n) begin
      if (ph != FREE) e_gnt = (own == 0) ? 2'b01 : 2'b10;
      case (ph)
        FREE: begin
          if (g_arv(0) && g_arv(1)) win = 1 - last;
          else if (g_arv(0)) win = 0;
          else if (g_arv(1)) win = 1;
          if (win >= 0) e_arrdy[win] = 1'b1;
        end
        AR_OUT: e_sarv = 1'b1;
        R_WAIT: begin
          e_rv[own] = s_if.RVALID;
          e_rd[own] = s_if.RDATA;
          e_rr[own] = s_if.RRESP;
          e_srrdy   = g_rrdy(own);
          e_to      = !s_if.RVALID && (quiet == TO);
        end
        ERR_RESP: begin
          e_rv[own] = 1'b1;
          e_rr[own] = 2'b10;
        end
        SINK: e_srrdy = 1'b1;
        default: ;
      endcase
    end
  endfunction

  function automatic void model_update();
    if (!rst_n) begin
      ph = FREE; own = -1; last = 0; maddr = '0; quiet = 0;
      return;
    end
    case (ph)
      FREE: if (win >= 0) begin
        own = win; last = win; maddr = g_ara(win); ph = AR_OUT;
      end
      AR_OUT: if (s_if.ARREADY) begin ph = R_WAIT; quiet = 0; end
      R_WAIT: begin
        if (s_if.RVALID && g_rrdy(own)) begin ph = FREE; own = -1; maddr = '0; end
        else if (!s_if.RVALID) begin
          if (quiet == TO) ph = ERR_RESP;
          else quiet++;
        end
      end
      ERR_RESP: if (g_rrdy(own)) ph = SINK;
      SINK: if (s_if.RVALID) begin ph = FREE; own = -1; maddr = '0; end
      default: ph = FREE;
    endcase
  endfunction

  function automatic void compare();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("m%0d_arready", i), d_arrdy(i), e_arrdy[i]);
      chk($sformatf("m%0d_rvalid", i), d_rv(i), e_rv[i]);
      chk($sformatf("m%0d_rdata", i), d_rd(i), e_rd[i]);
      chk($sformatf("m%0d_rresp", i), d_rr(i), e_rr[i]);
    end
    chk("s_arvalid", s_if.ARVALID, e_sarv);
    if (e_sarv) chk("s_araddr", s_if.ARADDR, maddr);
    chk("s_rready", s_if.RREADY, e_srrdy);
    chk("grant", grant, e_gnt);
    chk("timeout_err", timeout_err, e_to);
  endfunction

  // ---------------- observation logs (from DUT) ----------------
  int acc_log [$];
  int beats [2];
  int n_to = 0;

  // ---------------- auto stimulus state ----------------
  logic        hs_ar [2];
  logic        hs_sar, hs_r;
  logic        m_v [2];
  logic [63:0] m_a [2];
  logic        m_rdy [2];
  int          quota [2];
  int          req_pct, rdy_pct, sar_pct, dmax;
  logic        s_pend, s_rv, s_ardy;
  int          s_dly;
  logic [63:0] s_rd;
  logic [1:0]  s_rr;

  task automatic cycle();
    #1;
    compute_exp();
    compare();
    for (int i = 0; i < 2; i++) begin
      hs_ar[i] = g_arv(i) && e_arrdy[i];
      if (d_arrdy(i) && g_arv(i)) acc_log.push_back(i);
      if (d_rv(i) && g_rrdy(i)) beats[i]++;
    end
    if (timeout_err) n_to++;
    hs_sar = e_sarv && s_if.ARREADY;
    hs_r   = s_if.RVALID && e_srrdy;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive_auto();
    for (int i = 0; i < 2; i++) begin
      if (hs_ar[i]) m_v[i] = 1'b0;
      if (!m_v[i] && quota[i] > 0 && int'($urandom_range(99)) < req_pct) begin
        m_v[i] = 1'b1; m_a[i] = {$urandom, $urandom}; quota[i]--;
      end
      m_rdy[i] = int'($urandom_range(99)) < rdy_pct;
    end
    if (!rst_n) begin s_pend = 1'b0; s_rv = 1'b0; end
    if (hs_r) begin s_rv = 1'b0; s_pend = 1'b0; end
    if (hs_sar) begin s_pend = 1'b1; s_dly = int'($urandom_range(dmax)); end
    if (s_pend && !s_rv) begin
      if (s_dly == 0) begin
        s_rv = 1'b1; s_rd = {$urandom, $urandom};
        s_rr = $urandom_range(1) ? 2'b10 : 2'b00;
      end else s_dly--;
    end
    if (!s_rv) s_rd = {$urandom, $urandom};
    s_ardy = int'($urandom_range(99)) < sar_pct;
    m0_if.ARVALID = m_v[0]; m0_if.ARADDR = m_a[0]; m0_if.RREADY = m_rdy[0];
    m1_if.ARVALID = m_v[1]; m1_if.ARADDR = m_a[1]; m1_if.RREADY = m_rdy[1];
    s_if.ARREADY = s_ardy; s_if.RVALID = s_rv; s_if.RDATA = s_rd; s_if.RRESP = s_rr;
  endtask

  task automatic zero_inputs();
    m0_if.ARVALID = 0; m0_if.ARADDR = '0; m0_if.RREADY = 0;
    m1_if.ARVALID = 0; m1_if.ARADDR = '0; m1_if.RREADY = 0;
    s_if.ARREADY = 0; s_if.RVALID = 0; s_if.RDATA = '0; s_if.RRESP = 2'b00;
    for (int i = 0; i < 2; i++) begin
      m_v[i] = 0; m_a[i] = '0; m_rdy[i] = 0; hs_ar[i] = 0;
    end
    s_pend = 0; s_rv = 0; s_ardy = 0; s_dly = 0; s_rd = '0; s_rr = 2'b00;
    hs_sar = 0; hs_r = 0;
  endtask

  task automatic hard_reset();
    zero_inputs();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  // Single M0 transaction up to the first DATA cycle (accept + AR handshake)
  task automatic m0_to_data(input logic [63:0] a);
    m0_if.ARVALID = 1; m0_if.ARADDR = a; s_if.ARREADY = 1;
    cycle();
    m0_if.ARVALID = 0;
    cycle();
    s_if.ARREADY = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, got none expected summary");
    $fatal(1);
  end

  initial begin
    int exp_order [4];
    logic [63:0] ad;
    logic [63:0] dv;
    exp_order[0] = 1; exp_order[1] = 0; exp_order[2] = 1; exp_order[3] = 0;

    // ---- D1: single M1 read, minimum latency ----
    hard_reset();
    #1 chk("d1_reset_grant", grant, 2'b00);
    m1_if.ARVALID = 1; m1_if.ARADDR = 64'h8000_0010; s_if.ARREADY = 1;
    #1 chk("d1_c0_m1_arready", m1_if.ARREADY, 1'b1);
    cycle();
    m1_if.ARVALID = 0;
    #1 chk("d1_c1_s_arvalid", s_if.ARVALID, 1'b1);
    chk("d1_c1_s_araddr", s_if.ARADDR, 64'h8000_0010);
    chk("d1_c1_grant", grant, 2'b10);
    cycle();
    s_if.ARREADY = 0; s_if.RVALID = 1; s_if.RDATA = 64'hDEAD_BEEF; s_if.RRESP = 2'b00; m1_if.RREADY = 1;
    #1 chk("d1_c2_m1_rvalid", m1_if.RVALID, 1'b1);
    chk("d1_c2_m1_rdata", m1_if.RDATA, 64'hDEAD_BEEF);
    chk("d1_c2_m1_rresp", m1_if.RRESP, 2'b00);
    chk("d1_c2_grant", grant, 2'b10);
    cycle();
    s_if.RVALID = 0; m1_if.RREADY = 0;
    #1 chk("d1_c3_grant_idle", grant, 2'b00);
    cycle();

    // ---- D2: continuous tie, 4 transactions ----
    hard_reset();
    acc_log.delete(); beats[0] = 0; beats[1] = 0;
    quota[0] = 2; quota[1] = 2;
    req_pct = 100; rdy_pct = 100; sar_pct = 100; dmax = 0;
    for (int c = 0; c < 60 && (beats[0] + beats[1]) < 4; c++) begin
      drive_auto();
      cycle();
    end
    chk("d2_accept_count", acc_log.size(), 4);
    for (int k = 0; k < 4 && k < acc_log.size(); k++)
      chk($sformatf("d2_order_%0d", k), acc_log[k], exp_order[k]);
    chk("d2_m0_beats", beats[0], 2);
    chk("d2_m1_beats", beats[1], 2);

    // ---- D3: M1 waits while M0 is stuck in ADDR ----
    hard_reset();
    ad = 64'h0000_1234_5678_9ABC;
    m0_if.ARVALID = 1; m0_if.ARADDR = ad; s_if.ARREADY = 0;
    cycle();
    m0_if.ARVALID = 0; m1_if.ARVALID = 1; m1_if.ARADDR = 64'h42;
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("d3_s_araddr_%0d", k), s_if.ARADDR, ad);
      chk($sformatf("d3_m1_arready_%0d", k), m1_if.ARREADY, 1'b0);
      cycle();
    end
    s_if.ARREADY = 1;
    cycle();
    s_if.ARREADY = 0; s_if.RVALID = 1; s_if.RDATA = 64'h77; m0_if.RREADY = 1;
    #1 chk("d3_m1_arready_data", m1_if.ARREADY, 1'b0);
    cycle();
    s_if.RVALID = 0; m0_if.RREADY = 0;
    #1 chk("d3_m1_arready_idle", m1_if.ARREADY, 1'b1);
    cycle();

    // ---- D4: watchdog, SLVERR, drain ----
    hard_reset();
    n_to = 0;
    m0_to_data(64'h100);
    for (int k = 1; k <= 5; k++) begin
      #1 chk($sformatf("d4_timeout_k%0d", k), timeout_err, (k == 5) ? 1'b1 : 1'b0);
      cycle();
    end
    #1 chk("d4_err_rvalid", m0_if.RVALID, 1'b1);
    chk("d4_err_rresp", m0_if.RRESP, 2'b10);
    chk("d4_err_rdata", m0_if.RDATA, 64'h0);
    chk("d4_err_s_rready", s_if.RREADY, 1'b0);
    cycle();
    m0_if.RREADY = 1;
    cycle();
    m0_if.RREADY = 0; s_if.RVALID = 1; s_if.RDATA = 64'h5555;
    #1 chk("d4_drain_s_rready", s_if.RREADY, 1'b1);
    chk("d4_drain_m0_rvalid", m0_if.RVALID, 1'b0);
    chk("d4_drain_grant", grant, 2'b01);
    cycle();
    s_if.RVALID = 0;
    #1 chk("d4_back_idle", grant, 2'b00);
    chk("d4_pulse_count", n_to, 1);
    cycle();

    // ---- D5: reset mid-DATA ----
    hard_reset();
    m0_to_data(64'h200);
    s_if.RVALID = 1; s_if.RDATA = 64'hABCD; m0_if.RREADY = 0;
    m0_if.ARVALID = 1; m1_if.ARVALID = 1; m1_if.ARADDR = 64'h300;
    cycle();
    rst_n = 0;
    #1 chk("d5_rst_grant", grant, 2'b00);
    chk("d5_rst_m0_rvalid", m0_if.RVALID, 1'b0);
    chk("d5_rst_s_rready", s_if.RREADY, 1'b0);
    chk("d5_rst_m1_arready", m1_if.ARREADY, 1'b0);
    chk("d5_rst_s_araddr", s_if.ARADDR, 64'h0);
    cycle();
    s_if.RVALID = 0;
    rst_n = 1;
    #1 chk("d5_tie_m1_arready", m1_if.ARREADY, 1'b1);
    chk("d5_tie_m0_arready", m0_if.ARREADY, 1'b0);
    cycle();

    // ---- D6: master back-pressure on R ----
    hard_reset();
    beats[0] = 0; n_to = 0;
    m0_to_data(64'h400);
    dv = 64'hFEED_F00D_1234_0001;
    s_if.RVALID = 1; s_if.RDATA = dv; m0_if.RREADY = 0;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("d6_s_rready_%0d", k), s_if.RREADY, 1'b0);
      chk($sformatf("d6_rdata_%0d", k), m0_if.RDATA, dv);
      cycle();
    end
    m0_if.RREADY = 1;
    cycle();
    s_if.RVALID = 0; m0_if.RREADY = 0;
    for (int k = 0; k < 6; k++) cycle();
    chk("d6_one_handshake", beats[0], 1);
    chk("d6_no_timeout", n_to, 0);

    // ---- D7: data arrives on the terminal count ----
    hard_reset();
    n_to = 0;
    m0_to_data(64'h500);
    for (int k = 0; k < 4; k++) cycle();
    s_if.RVALID = 1; s_if.RDATA = 64'h99; m0_if.RREADY = 1;
    #1 chk("d7_no_timeout", timeout_err, 1'b0);
    chk("d7_rresp_ok", m0_if.RRESP, 2'b00);
    cycle();
    s_if.RVALID = 0; m0_if.RREADY = 0;
    #1 chk("d7_idle", grant, 2'b00);
    chk("d7_no_pulse", n_to, 0);
    cycle();

    // ---- Random traffic with occasional async reset ----
    hard_reset();
    quota[0] = 100000; quota[1] = 100000;
    req_pct = 40; rdy_pct = 70; sar_pct = 60; dmax = 7;
    begin
      int rst_hold = 0;
      for (int c = 0; c < 3000; c++) begin
        drive_auto();
        if (!rst_n) begin
          if (rst_hold == 0) rst_n = 1'b1;
          else rst_hold--;
        end else if ($urandom_range(249) == 0) begin
          rst_n = 1'b0;
          rst_hold = int'($urandom_range(1));
        end
        cycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
